spi_xfer_queue: RTL and testbench
=================================

// Module: spi_xfer_queue
// PURPOSE
//  Byte-stream front end for the SPI master. Buffers host TX bytes and issues
//  them to the master one transfer at a time via start/tx_data. Captures
//  rx_data on each done pulse into an RX FIFO returned to the host.
//  Sits directly upstream of the SPI master, on the same clock domain.
// PARAMETERS
//  DEPTH        8     entries per FIFO; power of 2, >= 2
//  TIMEOUT_CYC  4096  watchdog limit in clk cycles (used only with SPI_XQ_TIMEOUT_EN)
// PORTS
//  clk          in   1                  system clock; all logic on posedge
//  rst          in   1                  synchronous, active-high reset
//  tx_valid     in   1                  host TX byte valid
//  tx_ready     out  1                  TX FIFO can accept (= !tx_full)
//  tx_byte      in   8                  host TX byte
//  rx_valid     out  1                  RX FIFO not empty
//  rx_ready     in   1                  host pops RX head
//  rx_byte      out  8                  RX FIFO head (combinational read)
//  spi_start    out  1                  to master start; 1-cycle pulse
//  spi_tx_data  out  8                  to master tx_data; registered
//  spi_busy     in   1                  from master busy
//  spi_done     in   1                  from master done; 1-cycle pulse, rx_data valid
//  spi_rx_data  in   8                  from master rx_data
//  tx_level     out  $clog2(DEPTH)+1    TX FIFO occupancy
//  rx_level     out  $clog2(DEPTH)+1    RX FIFO occupancy
//  idle         out  1                  state==IDLE && tx_level==0
//  err_timeout  out  1                  1-cycle pulse on watchdog abort; const 0 without macro
// BEHAVIOUR
//  Reset: both FIFOs empty; state IDLE; spi_start=0; spi_tx_data=8'h00;
//   err_timeout=0; tx_ready=1; rx_valid=0; idle=1. Reset mid-transfer drops
//   the in-flight byte. The master shares rst.
//  FSM (registered state):
//   IDLE: if tx_level!=0 && rx_level<DEPTH, then load spi_tx_data<=TX head,
//    pop TX, and go to LAUNCH. rx_level<DEPTH guarantees space for the reply.
//   LAUNCH: spi_start=1 for exactly this cycle; spi_tx_data is held; go to WAIT_DONE.
//   WAIT_DONE: on spi_done, push spi_rx_data to RX and go to IDLE.
//  spi_start is decoded from state==LAUNCH. It is never high for two consecutive cycles.
//  spi_done in IDLE or LAUNCH is ignored; no push occurs.
//  Latency: byte accepted at cycle N -> IDLE sees it at N+1 -> spi_start at N+2.
//   done at cycle M -> rx_valid at M+1 -> next spi_start at M+2 at the earliest.
//  TX push only when tx_valid&&tx_ready. When full, a push is refused even if a
//   pop occurs in the same cycle.
//  RX: simultaneous push and pop are allowed; level is unchanged.
//   Pop when empty is ignored. Push never occurs when full (guaranteed by the IDLE check).
//  Levels are DEPTH+1-valued counters. FIFO pointers wrap modulo DEPTH.
//  spi_busy is used only by the optional watchdog.
//   It is not required for the start/done handshake.
// CONFIGURATION
//  SPI_XQ_TIMEOUT_EN defined:
//   - A counter clears in LAUNCH and increments each WAIT_DONE cycle.
//   - Reaching TIMEOUT_CYC-1 without spi_done: go to IDLE, push 8'hFF into RX
//     (host sees a byte per TX byte), and pulse err_timeout for 1 cycle.
//   - If spi_done arrives in that same cycle, done wins and there is no error.
//  Not defined: no counter; WAIT_DONE waits indefinitely; err_timeout tied to 0.
// STRUCTURE
//  Package spi_xq_pkg holds:
//   - typedef logic [7:0] spi_byte_t
//   - typedef enum {IDLE, LAUNCH, WAIT_DONE} spi_xq_state_e
//   - localparam TIMEOUT_FILL = 8'hFF
//  Sub-module spi_xq_fifo: sync FIFO with params WIDTH and DEPTH, a level
//   output, and combinational head; instantiated twice (TX, RX).
// TESTING
//  1 Reset with tx_valid=1 held: outputs at reset values; no spi_start while rst=1.
//  2 Single byte 8'hA5, model master returns 8'h3C after 20 cycles:
//    - spi_start at N+2 with spi_tx_data=8'hA5
//    - rx_byte=8'h3C with rx_valid at done+1
//  3 Push 8 bytes back-to-back:
//    - tx_ready drops after the 8th push
//    - 8 starts in order, with 8 replies in order
//  4 rx_ready=0 with 9 TX bytes:
//    - exactly 8 transfers, then the FSM stalls in IDLE with tx_level=1
//    - after 1 RX pop, the 9th spi_start fires
//  5 Reset asserted in WAIT_DONE:
//    - FIFOs empty, rx_valid=0
//    - later stray spi_done pushes nothing
//  6 [SPI_XQ_TIMEOUT_EN, TIMEOUT_CYC=16] master never pulses done:
//    - err_timeout pulses once
//    - RX holds 8'hFF; the next queued byte launches normally

Source files
------------

// File: rtl/spi_xq_pkg.sv
// Shared types and constants for the SPI transfer queue.
package spi_xq_pkg;

   typedef logic [7:0] spi_byte_t;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE
   } spi_xq_state_e;

   localparam spi_byte_t TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/spi_xfer_queue_if.sv
// Host-side byte stream bundle: TX bytes into the queue, RX bytes back out.
interface spi_xfer_queue_if;
   import spi_xq_pkg::*;

   logic      tx_valid;
   logic      tx_ready;
   spi_byte_t tx_byte;
   logic      rx_valid;
   logic      rx_ready;
   spi_byte_t rx_byte;

   modport master (
      output tx_valid, tx_byte, rx_ready,
      input  tx_ready, rx_valid, rx_byte
   );

   modport slave (
      input  tx_valid, tx_byte, rx_ready,
      output tx_ready, rx_valid, rx_byte
   );

endinterface

// File: rtl/spi_xq_fifo.sv
// Synchronous FIFO with combinational head and occupancy output.
// A push while full is refused even if a pop happens in the same cycle.
module spi_xq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_ok, pop_ok;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/spi_xfer_queue.sv
// Byte-stream front end for the SPI master: TX FIFO feeds one transfer at a time,
// replies land in an RX FIFO. Optional watchdog enabled by SPI_XQ_TIMEOUT_EN.
module spi_xfer_queue
   import spi_xq_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 4096,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   spi_xfer_queue_if.slave host,
   output logic            spi_start,
   output spi_byte_t       spi_tx_data,
   input  logic            spi_busy,
   input  logic            spi_done,
   input  spi_byte_t       spi_rx_data,
   output logic [LW-1:0]   tx_level,
   output logic [LW-1:0]   rx_level,
   output logic            idle,
   output logic            err_timeout
);

   spi_xq_state_e state_q, state_d;
   spi_byte_t     spi_tx_data_q, spi_tx_data_d;
   spi_byte_t     tx_head, rx_din;
   logic          tx_pop, rx_push;
   logic          tx_full, tx_empty, rx_full, rx_empty;

   spi_xq_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (host.tx_valid),
      .pop   (tx_pop),
      .din   (host.tx_byte),
      .dout  (tx_head),
      .level (tx_level),
      .full  (tx_full),
      .empty (tx_empty)
   );

   spi_xq_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (host.rx_ready),
      .din   (rx_din),
      .dout  (host.rx_byte),
      .level (rx_level),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign host.tx_ready = !tx_full;
   assign host.rx_valid = !rx_empty;
   assign spi_start     = (state_q == LAUNCH);
   assign spi_tx_data   = spi_tx_data_q;
   assign idle          = (state_q == IDLE) && tx_empty;

   logic unused_busy;
   assign unused_busy = spi_busy;

`ifdef SPI_XQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0] timer_q, timer_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
`endif

   // A byte is launched only when the RX FIFO is guaranteed to have room for its reply.
   always_comb begin
      state_d       = state_q;
      spi_tx_data_d = spi_tx_data_q;
      tx_pop        = 1'b0;
      rx_push       = 1'b0;
      rx_din        = spi_rx_data;
      err_timeout   = 1'b0;
`ifdef SPI_XQ_TIMEOUT_EN
      timer_d       = timer_q;
`endif
      case (state_q)
         IDLE: begin
            if (!tx_empty && !rx_full) begin
               spi_tx_data_d = tx_head;
               tx_pop        = 1'b1;
               state_d       = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT_DONE;
`ifdef SPI_XQ_TIMEOUT_EN
            timer_d = '0;
`endif
         end
         WAIT_DONE: begin
            if (spi_done) begin
               rx_push = 1'b1;
               state_d = IDLE;
            end
`ifdef SPI_XQ_TIMEOUT_EN
            else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
               // Fill byte keeps the host's one-reply-per-TX-byte accounting intact.
               rx_push     = 1'b1;
               rx_din      = TIMEOUT_FILL;
               err_timeout = 1'b1;
               state_d     = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         spi_tx_data_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         spi_tx_data_q <= spi_tx_data_d;
      end
   end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Scoreboard bench for spi_xfer_queue with a behavioural SPI master model.
// Expected launch order and reply bytes are queued at stimulus time and popped by monitors.
module tb_spi_xfer_queue;
   import spi_xq_pkg::*;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            spi_start, spi_busy, spi_done, idle, err_timeout;
   spi_byte_t       spi_tx_data, spi_rx_data;
   logic [LW-1:0]   tx_level, rx_level;

   spi_xfer_queue_if host_if();

   spi_xfer_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .host        (host_if),
      .spi_start   (spi_start),
      .spi_tx_data (spi_tx_data),
      .spi_busy    (spi_busy),
      .spi_done    (spi_done),
      .spi_rx_data (spi_rx_data),
      .tx_level    (tx_level),
      .rx_level    (rx_level),
      .idle        (idle),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_count  = 0;
   int check_count = 0;

   spi_byte_t exp_start_q[$];
   spi_byte_t exp_rx_q[$];
   spi_byte_t reply_q[$];

   int start_count    = 0;
   int done_count     = 0;
   int err_count      = 0;
   int last_start_cyc = -1;
   int done_cyc       = -1;
   int rx_rise_cyc    = -1;
   int accept_cyc     = -1;
   int rx_mode        = 1;
   int master_delay   = 3;
   bit master_hang    = 1'b0;
   bit rand_delay     = 1'b0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      check_count++;
      if (actual == expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Queue one host byte, its master reply and the byte the host should read back.
   task automatic applyStimulus(input spi_byte_t b, input spi_byte_t reply, input spi_byte_t exp_rx);
      int  waited;
      bit  got;
      logic rdy;
      int  c;
      waited = 0;
      got    = 1'b0;
      exp_start_q.push_back(b);
      reply_q.push_back(reply);
      exp_rx_q.push_back(exp_rx);
      host_if.tx_valid = 1'b1;
      host_if.tx_byte  = b;
      while (!got && waited < 2000) begin
         rdy = host_if.tx_ready;
         c   = cyc;
         @(posedge clk);
         if (rdy) begin
            got        = 1'b1;
            accept_cyc = c;
         end
         waited++;
      end
      #1;
      host_if.tx_valid = 1'b0;
      if (!got) checkOutput("tx_accept_timeout", 0, 1);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 3000 && (exp_rx_q.size() != 0 || exp_start_q.size() != 0); i++)
         waitCycles(1);
      checkOutput(name, exp_rx_q.size() + exp_start_q.size(), 0);
   endtask

   task automatic waitStart(input int target);
      for (int i = 0; i < 200 && start_count < target; i++) @(negedge clk);
      checkOutput("start_seen", start_count, target);
   endtask

   // Launch and RX scoreboards.
   initial begin
      logic prev_start;
      logic prev_rx_valid;
      prev_start    = 1'b0;
      prev_rx_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (spi_start) begin
            start_count++;
            last_start_cyc = cyc;
            checkOutput("start_gap", prev_start, 0);
            if (exp_start_q.size() == 0) checkOutput("start_unexpected", 1, 0);
            else checkOutput("spi_tx_data", spi_tx_data, exp_start_q.pop_front());
         end
         prev_start = spi_start;
         if (!rst && host_if.rx_valid && host_if.rx_ready) begin
            if (exp_rx_q.size() == 0) checkOutput("rx_unexpected", 1, 0);
            else checkOutput("rx_byte", host_if.rx_byte, exp_rx_q.pop_front());
         end
         if (host_if.rx_valid && !prev_rx_valid) rx_rise_cyc = cyc;
         prev_rx_valid = host_if.rx_valid;
         if (err_timeout) err_count++;
      end
   end

   // SPI master model: answers each start after a delay unless told to hang.
   initial begin
      spi_byte_t r;
      int d;
      spi_done    = 1'b0;
      spi_busy    = 1'b0;
      spi_rx_data = 8'h00;
      forever begin
         @(negedge clk);
         if (spi_start && !rst) begin
            r = 8'h00;
            if (reply_q.size() != 0) r = reply_q.pop_front();
            spi_busy = 1'b1;
            if (!master_hang) begin
               d = rand_delay ? int'($urandom_range(1, 6)) : master_delay;
               repeat (d) @(posedge clk);
               #1;
               spi_done    = 1'b1;
               spi_rx_data = r;
               done_cyc    = cyc;
               done_count++;
               @(posedge clk);
               #1;
               spi_done = 1'b0;
               spi_busy = 1'b0;
            end
         end
      end
   end

   // Host RX pop driver: 0 hold off, 1 always ready, 2 random, 3 single pop.
   initial begin
      host_if.rx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rx_mode)
            0: host_if.rx_ready = 1'b0;
            1: host_if.rx_ready = 1'b1;
            2: host_if.rx_ready = 1'($urandom_range(0, 1));
            default: begin
               host_if.rx_ready = 1'b1;
               rx_mode          = 0;
            end
         endcase
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "[TB] aborted");
   end

   initial begin
      int sc, dc, a, ec, exp_err;
      spi_byte_t b;

      // Reset with tx_valid held high.
      rst              = 1'b1;
      host_if.tx_valid = 1'b1;
      host_if.tx_byte  = 8'h77;
      rx_mode          = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_spi_start", spi_start, 0);
      checkOutput("rst_start_count", start_count, 0);
      checkOutput("rst_tx_ready", host_if.tx_ready, 1);
      checkOutput("rst_rx_valid", host_if.rx_valid, 0);
      checkOutput("rst_idle", idle, 1);
      checkOutput("rst_spi_tx_data", spi_tx_data, 0);
      checkOutput("rst_tx_level", tx_level, 0);
      checkOutput("rst_rx_level", rx_level, 0);
      checkOutput("rst_err_timeout", err_timeout, 0);
      @(posedge clk);
      #1;
      host_if.tx_valid = 1'b0;
      waitCycles(1);
      rst = 1'b0;
      waitCycles(2);

      // Single byte: launch latency and reply latency.
      rx_mode      = 0;
      master_delay = 20;
      sc           = start_count;
      dc           = done_count;
      applyStimulus(8'hA5, 8'h3C, 8'h3C);
      a = accept_cyc;
      waitStart(sc + 1);
      checkOutput("start_latency", last_start_cyc - a, 2);
      for (int i = 0; i < 60 && done_count == dc; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checkOutput("rx_latency", rx_rise_cyc - done_cyc, 1);
      checkOutput("rx_level_one", rx_level, 1);
      @(posedge clk);
      #1;
      rx_mode = 1;
      waitDrain("drain_single");

      // Back-to-back fill of the TX FIFO while one transfer is in flight.
      master_delay = 40;
      sc           = start_count;
      applyStimulus(8'h10, 8'h10 ^ 8'h5A, 8'h10 ^ 8'h5A);
      waitStart(sc + 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         b = 8'h20 + 8'(i);
         applyStimulus(b, b ^ 8'h5A, b ^ 8'h5A);
      end
      checkOutput("full_tx_ready", host_if.tx_ready, 0);
      checkOutput("full_tx_level", tx_level, 8);
      master_delay = 3;
      waitDrain("drain_burst");

      // RX back-pressure: 9 bytes, only 8 may launch until the host pops.
      rx_mode      = 0;
      master_delay = 2;
      sc           = start_count;
      for (int i = 0; i < 9; i++) begin
         b = 8'h40 + 8'(i);
         applyStimulus(b, 8'hC0 + 8'(i), 8'hC0 + 8'(i));
      end
      for (int i = 0; i < 300 && rx_level != 4'(DEPTH); i++) @(negedge clk);
      repeat (10) @(negedge clk);
      checkOutput("stall_starts", start_count - sc, 8);
      checkOutput("stall_tx_level", tx_level, 1);
      checkOutput("stall_rx_level", rx_level, 8);
      checkOutput("stall_idle", idle, 0);
      @(posedge clk);
      #1;
      rx_mode = 3;
      waitStart(sc + 9);
      rx_mode = 1;
      waitDrain("drain_backpressure");

      // Reset while waiting for done; the late done must not push anything.
      rx_mode      = 0;
      master_delay = 30;
      sc           = start_count;
      dc           = done_count;
      applyStimulus(8'h99, 8'h66, 8'h66);
      waitStart(sc + 1);
      @(posedge clk);
      #1;
      waitCycles(5);
      rst = 1'b1;
      waitCycles(2);
      exp_rx_q.delete();
      exp_start_q.delete();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_rx_valid", host_if.rx_valid, 0);
      checkOutput("midrst_tx_level", tx_level, 0);
      checkOutput("midrst_rx_level", rx_level, 0);
      for (int i = 0; i < 60 && done_count == dc; i++) @(negedge clk);
      checkOutput("stray_done_seen", done_count - dc, 1);
      repeat (3) @(negedge clk);
      checkOutput("stray_rx_valid", host_if.rx_valid, 0);
      checkOutput("stray_rx_level", rx_level, 0);
      checkOutput("stray_idle", idle, 1);
      @(posedge clk);
      #1;
      rx_mode = 1;

      exp_err = 0;
`ifdef SPI_XQ_TIMEOUT_EN
      // Master never answers: watchdog fills 8'hFF, then the next byte runs normally.
      master_hang = 1'b1;
      ec          = err_count;
      sc          = start_count;
      applyStimulus(8'hAA, 8'h00, TIMEOUT_FILL);
      waitStart(sc + 1);
      for (int i = 0; i < 100 && err_count == ec; i++) @(negedge clk);
      master_hang = 1'b0;
      spi_busy    = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(8'hBB, 8'h44, 8'h44);
      waitDrain("drain_timeout");
      checkOutput("timeout_pulses", err_count - ec, 1);
      exp_err = 1;
`endif

      // Randomised traffic with random reply latency and host back-pressure.
      rand_delay = 1'b1;
      rx_mode    = 2;
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         applyStimulus(b, ~b + 8'h11, ~b + 8'h11);
         waitCycles(int'($urandom_range(0, 3)));
      end
      waitDrain("drain_random");
      rx_mode = 1;
      waitCycles(4);
      @(negedge clk);
      checkOutput("final_idle", idle, 1);
      checkOutput("final_rx_valid", host_if.rx_valid, 0);
      checkOutput("err_count_total", err_count, exp_err);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
